// File: rtl/mac_dot_product_sequencer.sv
// rtl/mac_dot_product_sequencer.sv - operand buffer and sequencer driving an 8x8 MAC for dot products
//
// Purpose: collects a vector of up to DEPTH (b,c) operand pairs from an upstream
// valid/ready stream, clears the MAC, streams the pairs into it one per cycle with
// the accumulate enable delayed by MULT_LAT, then captures the accumulator and
// offers it downstream on a valid/ready result port.
//
// Ports:
//   clk, nreset             clock, synchronous active-low reset
//   s_valid/s_ready         operand pair handshake; s_b, s_c operands; s_last ends vector
//   mac_b, mac_c            operands to the MAC multiplier
//   mac_en, mac_rst         latency-aligned accumulate enable, active-high MAC clear
//   mac_a                   MAC accumulator value
//   m_valid/m_ready         result handshake; m_data dot product, m_count pair count

module mac_dot_product_sequencer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int MULT_LAT = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_b,
  input  logic [7:0]    s_c,
  input  logic          s_last,
  output logic [7:0]    mac_b,
  output logic [7:0]    mac_c,
  output logic          mac_en,
  output logic          mac_rst,
  input  logic [15:0]   mac_a,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   m_data,
  output logic [AW:0]   m_count
);

  typedef enum logic [2:0] {LOAD, CLEAR, STREAM, DRAIN, HOLD} state_t;

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  state_t              state;
  logic [AW:0]         count;
  logic [AW:0]         idx;
  logic [7:0]          b_mem [DEPTH];
  logic [7:0]          c_mem [DEPTH];
  logic [MULT_LAT-1:0] en_dly;
  logic [MULT_LAT:0]   en_next;
  logic                accept;
  logic                load_pair;

  assign s_ready = (state == LOAD) && (count < DEPTH_N);
  assign accept  = s_valid && s_ready;

  // The MAC must be held clear whenever this block is in reset so an aborted
  // vector cannot leak into the next accumulation.
  assign mac_rst = !nreset || (state == CLEAR);

  // A pair is placed on mac_b/mac_c at the next edge; CLEAR preloads pair 0.
  assign load_pair = (state == CLEAR) || ((state == STREAM) && (idx < count));
  assign en_next   = {en_dly, load_pair};

  // Operand storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (accept) begin
      b_mem[count[AW-1:0]] <= s_b;
      c_mem[count[AW-1:0]] <= s_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state   <= LOAD;
      count   <= '0;
      idx     <= '0;
      en_dly  <= '0;
      mac_en  <= 1'b0;
      mac_b   <= 8'd0;
      mac_c   <= 8'd0;
      m_valid <= 1'b0;
      m_data  <= 16'd0;
      m_count <= '0;
    end else begin
      // The delay line shifts every cycle, so DRAIN naturally flushes it with 0s.
      en_dly <= en_next[MULT_LAT-1:0];
      mac_en <= en_dly[MULT_LAT-1];
      mac_b  <= 8'd0;
      mac_c  <= 8'd0;

      case (state)
        LOAD: begin
          if (accept) begin
            count <= count + 1'b1;
            if (s_last || (count == DEPTH_N - 1'b1)) state <= CLEAR;
          end
        end
        CLEAR: begin
          mac_b <= b_mem[0];
          mac_c <= c_mem[0];
          idx   <= (AW+1)'(1);
          state <= STREAM;
        end
        STREAM: begin
          if (idx < count) begin
            mac_b <= b_mem[idx[AW-1:0]];
            mac_c <= c_mem[idx[AW-1:0]];
            idx   <= idx + 1'b1;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Delay line empty and the final enable already seen by the
          // accumulator, so mac_a now holds the complete sum.
          if ((en_dly == '0) && !mac_en) begin
            m_data  <= mac_a;
            m_count <= count;
            m_valid <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            count   <= '0;
            state   <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_product_sequencer.sv
// tb/tb_mac_dot_product_sequencer.sv - scoreboard bench for mac_dot_product_sequencer with a behavioural MAC

module tb_mac_dot_product_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int ML    = 2;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_b = 8'd0;
  logic [7:0]    s_c = 8'd0;
  logic          s_last = 1'b0;
  logic [7:0]    mac_b;
  logic [7:0]    mac_c;
  logic          mac_en;
  logic          mac_rst;
  logic [15:0]   mac_a;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [15:0]   m_data;
  logic [AW:0]   m_count;

  mac_dot_product_sequencer #(.DEPTH(DEPTH), .AW(AW), .MULT_LAT(ML)) dut (
    .clk(clk), .nreset(nreset),
    .s_valid(s_valid), .s_ready(s_ready), .s_b(s_b), .s_c(s_c), .s_last(s_last),
    .mac_b(mac_b), .mac_c(mac_c), .mac_en(mac_en), .mac_rst(mac_rst), .mac_a(mac_a),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: product pipeline of ML stages feeding a clearable accumulator.
  logic [15:0] acc;
  logic [15:0] pp [ML];
  always @(posedge clk) begin
    pp[0] <= mac_b * mac_c;
    for (int i = 1; i < ML; i++) pp[i] <= pp[i-1];
    if (mac_rst) acc <= 16'd0;
    else if (mac_en) acc <= acc + pp[ML-1];
  end
  assign mac_a = acc;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [AW:0] n;
  } exp_t;
  exp_t q[$];

  int en_cnt = 0;
  int overlap = 0;
  int rise_cyc = 0;
  bit mv_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (mac_en && mac_rst) overlap++;
    if (mac_en) en_cnt++;
    if (m_valid && !mv_prev) rise_cyc = cyc;
    mv_prev = m_valid;
    if (nreset && m_valid && m_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got m_data=0x%0h m_count=%0d, required no result", m_data, m_count);
      end else begin
        e = q.pop_front();
        chk("m_data", 32'(m_data), 32'(e.d));
        chk("m_count", 32'(m_count), 32'(e.n));
      end
    end
  end

  int t_last = 0;

  task automatic send(input logic [7:0] b, input logic [7:0] c, input logic last);
    int w = 0;
    s_b = b; s_c = c; s_last = last; s_valid = 1'b1;
    while (!s_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      total++;
      $display("FAIL send_timeout: got s_ready=0 for %0d cycles, required 1", w);
    end
    t_last = cyc;
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL %s_timeout: got %0d pending results, required 0", name, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int w;
    int mv_seen;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_count", 32'(m_count), 32'd0);
    chk("rst_mac_en", 32'(mac_en), 32'd0);
    chk("rst_mac_b", 32'(mac_b), 32'd0);
    chk("rst_mac_c", 32'(mac_c), 32'd0);
    chk("rst_mac_rst", 32'(mac_rst), 32'd1);
    nreset = 1'b1;
    @(negedge clk);

    // Three pairs: 6 + 20 + 42 = 0x44.
    en_cnt = 0;
    q.push_back('{16'h0044, (AW+1)'(3)});
    send(8'd2, 8'd3, 1'b0);
    send(8'd4, 8'd5, 1'b0);
    send(8'd6, 8'd7, 1'b1);
    wait_result("t1");
    chk("t1_latency", 32'(rise_cyc - t_last), 32'd8);
    chk("t1_en_cycles", 32'(en_cnt), 32'd3);

    // Single pair; clear pulse precedes the pair by one cycle.
    q.push_back('{16'h0100, (AW+1)'(1)});
    send(8'h80, 8'h02, 1'b1);
    chk("t2_mac_rst_pulse", 32'(mac_rst), 32'd1);
    chk("t2_mac_b_idle", 32'(mac_b), 32'd0);
    @(negedge clk);
    chk("t2_mac_b", 32'(mac_b), 32'h80);
    chk("t2_mac_c", 32'(mac_c), 32'h02);
    chk("t2_mac_rst_low", 32'(mac_rst), 32'd0);
    wait_result("t2");

    // Full buffer without s_last: 16 * 65025 mod 2^16 = 0xE010.
    q.push_back('{16'hE010, (AW+1)'(16)});
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t3_s_ready_before_last", 32'(s_ready), 32'd1);
      send(8'd255, 8'd255, 1'b0);
    end
    chk("t3_s_ready_full", 32'(s_ready), 32'd0);
    wait_result("t3");

    // Result backpressure: 3*4 = 12.
    m_ready = 1'b0;
    q.push_back('{16'h000C, (AW+1)'(1)});
    send(8'd3, 8'd4, 1'b1);
    w = 0;
    while (!m_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_m_valid", 32'(m_valid), 32'd1);
      chk("t4_hold_m_data", 32'(m_data), 32'h000C);
      chk("t4_hold_m_count", 32'(m_count), 32'd1);
      chk("t4_hold_s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_after_m_valid", 32'(m_valid), 32'd0);
    chk("t4_after_s_ready", 32'(s_ready), 32'd1);
    chk("t4_popped", 32'(q.size()), 32'd0);

    // Back-to-back vectors; second must not inherit the first sum.
    q.push_back('{16'h0002, (AW+1)'(2)});
    q.push_back('{16'h0009, (AW+1)'(1)});
    send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    send(8'd3, 8'd3, 1'b1);
    wait_result("t5");

    // Reset during STREAM aborts the vector.
    send(8'd5, 8'd5, 1'b0);
    send(8'd5, 8'd5, 1'b0);
    send(8'd5, 8'd5, 1'b0);
    send(8'd5, 8'd5, 1'b1);
    @(negedge clk);
    nreset = 1'b0;
    #1 chk("t6_mac_rst_in_reset", 32'(mac_rst), 32'd1);
    @(negedge clk);
    nreset = 1'b1;
    chk("t6_s_ready", 32'(s_ready), 32'd1);
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_mac_en", 32'(mac_en), 32'd0);
    chk("t6_mac_b", 32'(mac_b), 32'd0);
    mv_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_valid) mv_seen++;
    end
    chk("t6_no_result", 32'(mv_seen), 32'd0);
    q.push_back('{16'h0001, (AW+1)'(1)});
    send(8'd1, 8'd1, 1'b1);
    wait_result("t6");

    chk("no_en_during_rst", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
